// File: rtl/arm_decode_stage_if.sv
// ============================================================================
// Module   : arm_decode_stage_if
// Brief    : Fetch-side handshake and decoded-uop bundle for arm_decode_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface arm_decode_stage_if #(
    parameter int RADDR_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic [3:0]         flags_nzcv;
    logic               out_valid;
    logic               out_ready;
    logic               alu_hot;
    logic               mult_hot;
    logic               reg_w;
    logic               s_on;
    logic               invert_a;
    logic               invert_b;
    logic               is_logic;
    logic               alu_cin;
    logic [2:0]         logicidx;
    logic [1:0]         special_in;
    logic               is_imm;
    logic               imm_shift;
    logic [7:0]         imm8;
    logic [2:0]         shifter_mode;
    logic [4:0]         shifter_count;
    logic [RADDR_W-1:0] rn;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rm;
    logic [RADDR_W-1:0] rs;
    logic [1:0]         mult_mode;
    logic               uop_hi;
    logic               cond_pass;
    logic               undef;

    modport slave (
        input  in_valid, in_instr, flags_nzcv, out_ready,
        output in_ready, out_valid, alu_hot, mult_hot, reg_w, s_on, invert_a, invert_b,
               is_logic, alu_cin, logicidx, special_in, is_imm, imm_shift, imm8,
               shifter_mode, shifter_count, rn, rd, rm, rs, mult_mode, uop_hi,
               cond_pass, undef
    );

    modport master (
        output in_valid, in_instr, flags_nzcv, out_ready,
        input  in_ready, out_valid, alu_hot, mult_hot, reg_w, s_on, invert_a, invert_b,
               is_logic, alu_cin, logicidx, special_in, is_imm, imm_shift, imm8,
               shifter_mode, shifter_count, rn, rd, rm, rs, mult_mode, uop_hi,
               cond_pass, undef
    );
endinterface

`default_nettype wire

// File: rtl/arm_decode_stage.sv
// ============================================================================
// Module   : arm_decode_stage
// Brief    : Registered ARM data-processing/multiply decoder with valid/ready flow control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arm_decode_stage #(
    parameter int RADDR_W  = 4,
    parameter bit LONG_MUL = 1'b1,
    parameter bit COND_EN  = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    arm_decode_stage_if.slave io
);
    typedef struct packed {
        logic               alu_hot;
        logic               mult_hot;
        logic               reg_w;
        logic               s_on;
        logic               invert_a;
        logic               invert_b;
        logic               is_logic;
        logic               alu_cin;
        logic [2:0]         logicidx;
        logic [1:0]         special_in;
        logic               is_imm;
        logic               imm_shift;
        logic [7:0]         imm8;
        logic [2:0]         shifter_mode;
        logic [4:0]         shifter_count;
        logic [RADDR_W-1:0] rn;
        logic [RADDR_W-1:0] rd;
        logic [RADDR_W-1:0] rm;
        logic [RADDR_W-1:0] rs;
        logic [1:0]         mult_mode;
        logic               uop_hi;
        logic               cond_pass;
        logic               undef;
    } uop_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FULL    = 2'd1,
        LONG_HI = 2'd2
    } state_t;

    state_t             state_q, state_d;
    uop_t               uop_q, uop_d, dec;
    logic [RADDR_W-1:0] rd_hi_q, rd_hi_d, dec_rd_hi;
    logic               long_q, long_d, dec_long;
    logic               cond_raw, cond_ok, undef_enc, accept;
    logic [31:0]        instr;
    logic               n_f, z_f, c_f, v_f;

    function automatic logic [RADDR_W-1:0] ridx(input logic [3:0] f);
        return RADDR_W'(f);
    endfunction

    assign instr                = io.in_instr;
    assign {n_f, z_f, c_f, v_f} = io.flags_nzcv;

    always_comb begin
        cond_raw = 1'b1;
        case (instr[31:28])
            4'h0:    cond_raw = z_f;
            4'h1:    cond_raw = !z_f;
            4'h2:    cond_raw = c_f;
            4'h3:    cond_raw = !c_f;
            4'h4:    cond_raw = n_f;
            4'h5:    cond_raw = !n_f;
            4'h6:    cond_raw = v_f;
            4'h7:    cond_raw = !v_f;
            4'h8:    cond_raw = c_f && !z_f;
            4'h9:    cond_raw = !c_f || z_f;
            4'hA:    cond_raw = (n_f == v_f);
            4'hB:    cond_raw = (n_f != v_f);
            4'hC:    cond_raw = !z_f && (n_f == v_f);
            4'hD:    cond_raw = z_f || (n_f != v_f);
            default: cond_raw = 1'b1;
        endcase
    end

    assign cond_ok = !COND_EN || cond_raw;

    always_comb begin
        dec       = '0;
        dec_long  = 1'b0;
        dec_rd_hi = '0;
        undef_enc = 1'b0;
        if (instr[27:24] == 4'b0000 && instr[7:4] == 4'b1001) begin
            dec.rm       = ridx(instr[3:0]);
            dec.rs       = ridx(instr[11:8]);
            dec.mult_hot = 1'b1;
            dec.reg_w    = 1'b1;
            dec.s_on     = instr[20];
            if (instr[23:22] == 2'b00) begin
                dec.mult_mode = {1'b0, instr[21]};
                dec.rd        = ridx(instr[19:16]);
                if (instr[21])
                    dec.rn = ridx(instr[15:12]);
            end else if (instr[23] && !instr[21] && LONG_MUL) begin
                // Low half goes out first; the high-half destination waits in rd_hi_q.
                dec.mult_mode = {1'b1, instr[22]};
                dec.rd        = ridx(instr[15:12]);
                dec_rd_hi     = ridx(instr[19:16]);
                dec_long      = 1'b1;
            end else begin
                undef_enc = 1'b1;
            end
        end else if (instr[27:26] == 2'b00) begin
            dec.rn      = ridx(instr[19:16]);
            dec.rd      = ridx(instr[15:12]);
            dec.s_on    = instr[20];
            dec.alu_hot = 1'b1;
            dec.reg_w   = 1'b1;
            if (instr[25]) begin
                dec.is_imm        = 1'b1;
                dec.imm8          = instr[7:0];
                dec.shifter_mode  = 3'b100;
                dec.shifter_count = {instr[11:8], 1'b0};
                dec.imm_shift     = 1'b1;
            end else begin
                dec.rm           = ridx(instr[3:0]);
                dec.shifter_mode = {1'b0, instr[6:5]};
                if (!instr[4]) begin
                    dec.shifter_count = instr[11:7];
                    dec.imm_shift     = 1'b1;
                end else begin
                    dec.rs = ridx(instr[11:8]);
                    if (instr[7])
                        undef_enc = 1'b1;
                end
            end
            case (instr[24:21])
                4'h0: dec.is_logic = 1'b1;
                4'h1: begin dec.is_logic = 1'b1; dec.logicidx = 3'd2; end
                4'h2: begin dec.invert_b = 1'b1; dec.alu_cin = 1'b1; end
                4'h3: begin dec.invert_a = 1'b1; dec.alu_cin = 1'b1; end
                4'h4: ;
                4'h5: dec.alu_cin = c_f;
                4'h6: begin dec.invert_b = 1'b1; dec.alu_cin = c_f; end
                4'h7: begin dec.invert_a = 1'b1; dec.alu_cin = c_f; end
                4'h8: begin dec.is_logic = 1'b1; dec.reg_w = 1'b0; end
                4'h9: begin dec.is_logic = 1'b1; dec.logicidx = 3'd2; dec.reg_w = 1'b0; end
                4'hA: begin dec.invert_b = 1'b1; dec.alu_cin = 1'b1; dec.reg_w = 1'b0; end
                4'hB: dec.reg_w = 1'b0;
                4'hC: begin dec.is_logic = 1'b1; dec.logicidx = 3'd1; end
                4'hD: dec.alu_hot = 1'b0;
                4'hE: begin dec.is_logic = 1'b1; dec.invert_b = 1'b1; end
                default: begin
                    // MVN: operand A forced to constant 0, result = 0 | ~B.
                    dec.special_in = 2'b10;
                    dec.is_logic   = 1'b1;
                    dec.logicidx   = 3'd1;
                    dec.invert_b   = 1'b1;
                end
            endcase
            // Compare-class opcodes without S are PSR/branch-exchange space.
            if (instr[24:23] == 2'b10 && !instr[20])
                undef_enc = 1'b1;
        end else begin
            undef_enc = 1'b1;
        end
        if (instr[31:28] == 4'hF)
            undef_enc = 1'b1;
        dec.cond_pass = cond_ok;
        if (undef_enc) begin
            dec.undef    = 1'b1;
            dec.reg_w    = 1'b0;
            dec.s_on     = 1'b0;
            dec.mult_hot = 1'b0;
            dec.alu_hot  = 1'b0;
            dec_long     = 1'b0;
        end else if (!cond_ok) begin
            dec.reg_w = 1'b0;
            dec.s_on  = 1'b0;
        end
    end

    assign io.in_ready = !rst && (state_q == IDLE ||
                                  (state_q == FULL && io.out_ready && !long_q));
    assign accept      = io.in_valid && io.in_ready;

    always_comb begin
        state_d = state_q;
        uop_d   = uop_q;
        rd_hi_d = rd_hi_q;
        long_d  = long_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FULL;
                    uop_d   = dec;
                    rd_hi_d = dec_rd_hi;
                    long_d  = dec_long;
                end
            end
            FULL: begin
                if (io.out_ready) begin
                    if (long_q) begin
                        state_d      = LONG_HI;
                        uop_d.rd     = rd_hi_q;
                        uop_d.uop_hi = 1'b1;
                        long_d       = 1'b0;
                    end else if (accept) begin
                        uop_d   = dec;
                        rd_hi_d = dec_rd_hi;
                        long_d  = dec_long;
                    end else begin
                        state_d = IDLE;
                        uop_d   = '0;
                    end
                end
            end
            LONG_HI: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                    uop_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                uop_d   = '0;
                long_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            uop_q   <= '0;
            rd_hi_q <= '0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            uop_q   <= uop_d;
            rd_hi_q <= rd_hi_d;
            long_q  <= long_d;
        end
    end

    assign io.out_valid     = (state_q != IDLE);
    assign io.alu_hot       = uop_q.alu_hot;
    assign io.mult_hot      = uop_q.mult_hot;
    assign io.reg_w         = uop_q.reg_w;
    assign io.s_on          = uop_q.s_on;
    assign io.invert_a      = uop_q.invert_a;
    assign io.invert_b      = uop_q.invert_b;
    assign io.is_logic      = uop_q.is_logic;
    assign io.alu_cin       = uop_q.alu_cin;
    assign io.logicidx      = uop_q.logicidx;
    assign io.special_in    = uop_q.special_in;
    assign io.is_imm        = uop_q.is_imm;
    assign io.imm_shift     = uop_q.imm_shift;
    assign io.imm8          = uop_q.imm8;
    assign io.shifter_mode  = uop_q.shifter_mode;
    assign io.shifter_count = uop_q.shifter_count;
    assign io.rn            = uop_q.rn;
    assign io.rd            = uop_q.rd;
    assign io.rm            = uop_q.rm;
    assign io.rs            = uop_q.rs;
    assign io.mult_mode     = uop_q.mult_mode;
    assign io.uop_hi        = uop_q.uop_hi;
    assign io.cond_pass     = uop_q.cond_pass;
    assign io.undef         = uop_q.undef;
endmodule

`default_nettype wire

// File: tb/tb_arm_decode_stage.sv
// ============================================================================
// Module   : tb_arm_decode_stage
// Brief    : Directed-vector bench for arm_decode_stage with hand-computed expectations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_arm_decode_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    arm_decode_stage_if #(.RADDR_W(4)) bus ();

    arm_decode_stage #(
        .RADDR_W  (4),
        .LONG_MUL (1'b1),
        .COND_EN  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction at a falling edge, let it be taken on the next rising edge.
    task automatic issue(input logic [31:0] instr, input logic [3:0] nzcv);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_instr   = instr;
        bus.flags_nzcv = nzcv;
        check("issue_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_instr   = 32'h0;
        bus.flags_nzcv = 4'h0;
        bus.out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_rd",        bus.rd,        0);
        check("rst_reg_w",     bus.reg_w,     0);
        rst = 1'b0;
        #1 check("idle_in_ready", bus.in_ready, 1);

        // ADD r1,r2,#5
        issue(32'hE2821005, 4'h0);
        check("add_valid",  bus.out_valid,    1);
        check("add_rd",     bus.rd,           1);
        check("add_rn",     bus.rn,           2);
        check("add_is_imm", bus.is_imm,       1);
        check("add_imm8",   bus.imm8,         8'h05);
        check("add_reg_w",  bus.reg_w,        1);
        check("add_cin",    bus.alu_cin,      0);
        check("add_alu",    bus.alu_hot,      1);
        check("add_mode",   bus.shifter_mode, 3'b100);

        // SUBS r3,r4,r5,LSL#2
        issue(32'hE0543105, 4'h0);
        check("subs_invb",  bus.invert_b,      1);
        check("subs_cin",   bus.alu_cin,       1);
        check("subs_s_on",  bus.s_on,          1);
        check("subs_rm",    bus.rm,            5);
        check("subs_mode",  bus.shifter_mode,  3'b000);
        check("subs_count", bus.shifter_count, 2);
        check("subs_ishft", bus.imm_shift,     1);

        // SBC r1,r2,r3 with C=1: carry-in comes from flags
        issue(32'hE0C21003, 4'b0010);
        check("sbc_cin",  bus.alu_cin,  1);
        check("sbc_invb", bus.invert_b, 1);

        // CMP r1,#0: no write-back, flags updated
        issue(32'hE3510000, 4'h0);
        check("cmp_reg_w", bus.reg_w, 0);
        check("cmp_s_on",  bus.s_on,  1);

        // MVN r0,r1
        issue(32'hE1E00001, 4'h0);
        check("mvn_special", bus.special_in, 2'b10);
        check("mvn_reg_w",   bus.reg_w,      1);
        check("mvn_rm",      bus.rm,         1);

        // UMULL r0,r1,r2,r3: two uops, no accept in between
        issue(32'hE0810392, 4'h0);
        check("umull_lo_valid", bus.out_valid, 1);
        check("umull_lo_rd",    bus.rd,        0);
        check("umull_lo_hi",    bus.uop_hi,    0);
        check("umull_lo_mode",  bus.mult_mode, 2);
        check("umull_lo_mult",  bus.mult_hot,  1);
        check("umull_lo_alu",   bus.alu_hot,   0);
        check("umull_lo_rm",    bus.rm,        2);
        check("umull_lo_rs",    bus.rs,        3);
        check("umull_lo_rdy",   bus.in_ready,  0);
        @(negedge clk);
        check("umull_hi_valid", bus.out_valid, 1);
        check("umull_hi_rd",    bus.rd,        1);
        check("umull_hi_hi",    bus.uop_hi,    1);
        check("umull_hi_mode",  bus.mult_mode, 2);
        check("umull_hi_rdy",   bus.in_ready,  0);
        @(negedge clk);
        check("umull_done", bus.out_valid, 0);

        // UMLAL is unsupported: single annulled uop
        issue(32'hE0A10392, 4'h0);
        check("umlal_undef", bus.undef,    1);
        check("umlal_reg_w", bus.reg_w,    0);
        check("umlal_mult",  bus.mult_hot, 0);
        @(negedge clk);
        check("umlal_single", bus.out_valid, 0);

        // cond 1111 is undefined
        issue(32'hF2821005, 4'h0);
        check("nv_undef", bus.undef, 1);
        check("nv_reg_w", bus.reg_w, 0);

        // ADDEQ with Z=0 then Z=1
        issue(32'h02821005, 4'b0000);
        check("addeq_z0_valid", bus.out_valid, 1);
        check("addeq_z0_pass",  bus.cond_pass, 0);
        check("addeq_z0_reg_w", bus.reg_w,     0);
        issue(32'h02821005, 4'b0100);
        check("addeq_z1_pass",  bus.cond_pass, 1);
        check("addeq_z1_reg_w", bus.reg_w,     1);

        // Back-pressure: ADD held three cycles while SUBS waits
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_instr   = 32'hE2821005;
        bus.flags_nzcv = 4'h0;
        @(posedge clk);
        #1 bus.in_instr = 32'hE0543105;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", bus.out_valid, 1);
            check("stall_rd",    bus.rd,        1);
            check("stall_imm8",  bus.imm8,      8'h05);
            check("stall_rdy",   bus.in_ready,  0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_rd",    bus.rd,        3);
        check("b2b_s_on",  bus.s_on,      1);
        @(negedge clk);
        check("b2b_nodup", bus.out_valid, 0);

        // Reset while the UMULL high uop is pending
        issue(32'hE0810392, 4'h0);
        check("rstmid_lo_rd", bus.rd, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_valid", bus.out_valid, 0);
        check("rstmid_rdy",   bus.in_ready,  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rstmid_no_hi_valid", bus.out_valid, 0);
            check("rstmid_no_hi_flag",  bus.uop_hi,    0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
